// File: rtl/rl_fixed_pkg.sv
// Shared fixed-point helpers for the RL accelerator blocks.
// Provides the default Q-format widths, the q_t scalar type and saturating
// add/sub/multiply-shift functions that return {value, sat}. Arithmetic is done
// in a wide acc_t so any WIDTH up to 31 bits is exact before clamping.
package rl_fixed_pkg;

    localparam int unsigned Q_WIDTH = 16;
    localparam int unsigned Q_FRAC  = 8;
    localparam int unsigned ACC_W   = 64;

    typedef logic signed [Q_WIDTH-1:0] q_t;
    typedef logic signed [ACC_W-1:0]   acc_t;

    // Saturated result: clamped value (sign-extended in acc_t) plus clamp flag.
    typedef struct packed {
        acc_t value;
        logic sat;
    } sat_res_t;

    // Clamp a wide value into the signed range of a w-bit word.
    function automatic sat_res_t sat_clamp(input acc_t x, input int unsigned w);
        acc_t     hi;
        acc_t     lo;
        sat_res_t r;
        hi = (acc_t'(1) <<< (w - 1)) - acc_t'(1);
        lo = -(acc_t'(1) <<< (w - 1));
        if (x > hi) begin
            r.value = hi;
            r.sat   = 1'b1;
        end else if (x < lo) begin
            r.value = lo;
            r.sat   = 1'b1;
        end else begin
            r.value = x;
            r.sat   = 1'b0;
        end
        return r;
    endfunction

    function automatic sat_res_t sat_add(input acc_t a, input acc_t b, input int unsigned w);
        return sat_clamp(a + b, w);
    endfunction

    function automatic sat_res_t sat_sub(input acc_t a, input acc_t b, input int unsigned w);
        return sat_clamp(a - b, w);
    endfunction

    // sat(addend + ((coef * x) >>> frac)); the scaled product is not clamped on
    // its own, only the final sum, so coefficients above 1.0 stay exact.
    function automatic sat_res_t sat_mul_shift(input acc_t x, input acc_t coef,
                                               input int unsigned frac, input acc_t addend,
                                               input int unsigned w);
        acc_t prod;
        prod = x * coef;
        return sat_clamp(addend + (prod >>> frac), w);
    endfunction

endpackage

// File: rtl/q_argmax_tracker.sv
// Running signed max / argmax / sticky-saturation tracker over one vector.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   beat_valid      a beat is consumed this cycle
//   beat_first      beat is index 0: loads the running state
//   beat_last       beat closes the vector: result is emitted next cycle
//   beat_q/idx/sat  value, action index and saturation flag of the beat
//   res_valid       one-cycle pulse carrying the vector result
//   res_q/idx/sat   max value, its index (lowest on ties), any saturation
module q_argmax_tracker #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned IDX_W = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    beat_valid,
    input  logic                    beat_first,
    input  logic                    beat_last,
    input  logic signed [WIDTH-1:0] beat_q,
    input  logic [IDX_W-1:0]        beat_idx,
    input  logic                    beat_sat,
    output logic                    res_valid,
    output logic signed [WIDTH-1:0] res_q,
    output logic [IDX_W-1:0]        res_idx,
    output logic                    res_sat
);

    logic signed [WIDTH-1:0] run_q;
    logic [IDX_W-1:0]        run_idx;
    logic                    run_sat;

    logic signed [WIDTH-1:0] cand_q;
    logic [IDX_W-1:0]        cand_idx;
    logic                    cand_sat;

    // Candidate state after folding in the current beat; strict > keeps the lowest index on ties.
    always_comb begin
        cand_q   = run_q;
        cand_idx = run_idx;
        cand_sat = run_sat | beat_sat;
        if (beat_first) begin
            cand_q   = beat_q;
            cand_idx = beat_idx;
            cand_sat = beat_sat;
        end else if (beat_q > run_q) begin
            cand_q   = beat_q;
            cand_idx = beat_idx;
        end
    end

    // Running state and held result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_q     <= '0;
            run_idx   <= '0;
            run_sat   <= 1'b0;
            res_valid <= 1'b0;
            res_q     <= '0;
            res_idx   <= '0;
            res_sat   <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            if (beat_valid) begin
                if (beat_last) begin
                    res_valid <= 1'b1;
                    res_q     <= cand_q;
                    res_idx   <= cand_idx;
                    res_sat   <= cand_sat;
                    run_q     <= '0;
                    run_idx   <= '0;
                    run_sat   <= 1'b0;
                end else begin
                    run_q     <= cand_q;
                    run_idx   <= cand_idx;
                    run_sat   <= cand_sat;
                end
            end
        end
    end

endmodule

// File: rtl/q_update_argmax_stream.sv
// Streaming Bellman Q-update plus per-vector argmax.
// Per state vector of ACTIONS beats: T = sat(reward + gamma*q_next_max >>> FRAC)
// taken from beat 0, then per beat D = sat(T - Q), Q' = sat(Q + alpha*D >>> FRAC).
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready/in_q    input Q(s,a) stream, one action per beat
//   reward, q_next_max        target scalars, sampled on beat 0 only
//   alpha, gamma              unsigned rates (1.0 = 2^FRAC), sampled on beat 0 only
//   upd_valid/upd_ready       updated-Q stream handshake
//   upd_q/upd_idx/upd_last    Q'(s,a), its action index, last-beat marker
//   res_valid                 one-cycle pulse after the last updated beat leaves
//   res_q/res_idx/res_sat     max Q', its argmax (lowest on ties), any saturation
module q_update_argmax_stream
    import rl_fixed_pkg::*;
#(
    parameter int unsigned  WIDTH   = Q_WIDTH,
    parameter int unsigned  FRAC    = Q_FRAC,
    parameter int unsigned  ACTIONS = 4,
    localparam int unsigned IDX_W   = $clog2(ACTIONS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_q,
    input  logic signed [WIDTH-1:0] reward,
    input  logic signed [WIDTH-1:0] q_next_max,
    input  logic [FRAC:0]           alpha,
    input  logic [FRAC:0]           gamma,
    output logic                    upd_valid,
    input  logic                    upd_ready,
    output logic signed [WIDTH-1:0] upd_q,
    output logic [IDX_W-1:0]        upd_idx,
    output logic                    upd_last,
    output logic                    res_valid,
    output logic signed [WIDTH-1:0] res_q,
    output logic [IDX_W-1:0]        res_idx,
    output logic                    res_sat
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ACTIONS - 1);

    // Flow control: the whole pipe moves together, frozen while the output is stalled.
    logic advance;
    logic accept;

    // Beat position and per-vector scalars latched from beat 0.
    logic [IDX_W-1:0]        beat_cnt;
    logic signed [WIDTH-1:0] t_lat;
    logic                    t_lat_sat;
    logic [FRAC:0]           alpha_lat;

    // Stage 1: difference D plus everything stage 2 needs.
    logic                    s1_valid;
    logic signed [WIDTH-1:0] s1_q;
    logic signed [WIDTH-1:0] s1_d;
    logic [FRAC:0]           s1_alpha;
    logic [IDX_W-1:0]        s1_idx;
    logic                    s1_sat;

    logic                    upd_sat;

    // Combinational datapath.
    sat_res_t                t_live_r;
    sat_res_t                d_r;
    sat_res_t                q_r;
    logic                    beat_first;
    logic signed [WIDTH-1:0] t_cur;
    logic                    t_cur_sat;
    logic [FRAC:0]           alpha_cur;

    assign advance    = !upd_valid || upd_ready;
    assign in_ready   = advance;
    assign accept     = in_valid && advance;
    assign beat_first = (beat_cnt == '0);

    // Beat 0 uses the live target/alpha; later beats reuse the values latched on beat 0.
    always_comb begin
        t_live_r  = sat_mul_shift(acc_t'(q_next_max), acc_t'({1'b0, gamma}), FRAC,
                                  acc_t'(reward), WIDTH);
        t_cur     = t_lat;
        t_cur_sat = t_lat_sat;
        alpha_cur = alpha_lat;
        if (beat_first) begin
            t_cur     = WIDTH'(t_live_r.value);
            t_cur_sat = t_live_r.sat;
            alpha_cur = alpha;
        end
        d_r = sat_sub(acc_t'(t_cur), acc_t'(in_q), WIDTH);
        q_r = sat_mul_shift(acc_t'(s1_d), acc_t'({1'b0, s1_alpha}), FRAC,
                            acc_t'(s1_q), WIDTH);
    end

    // Beat counter, scalar latch and the two pipeline stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt  <= '0;
            t_lat     <= '0;
            t_lat_sat <= 1'b0;
            alpha_lat <= '0;
            s1_valid  <= 1'b0;
            s1_q      <= '0;
            s1_d      <= '0;
            s1_alpha  <= '0;
            s1_idx    <= '0;
            s1_sat    <= 1'b0;
            upd_valid <= 1'b0;
            upd_q     <= '0;
            upd_idx   <= '0;
            upd_last  <= 1'b0;
            upd_sat   <= 1'b0;
        end else begin
            if (accept) begin
                beat_cnt <= (beat_cnt == LAST_IDX) ? '0 : beat_cnt + IDX_W'(1);
                if (beat_first) begin
                    t_lat     <= t_cur;
                    t_lat_sat <= t_cur_sat;
                    alpha_lat <= alpha;
                end
            end
            if (advance) begin
                s1_valid <= accept;
                if (accept) begin
                    s1_q     <= in_q;
                    s1_d     <= WIDTH'(d_r.value);
                    s1_alpha <= alpha_cur;
                    s1_idx   <= beat_cnt;
                    s1_sat   <= t_cur_sat | d_r.sat;
                end
                upd_valid <= s1_valid;
                if (s1_valid) begin
                    upd_q    <= WIDTH'(q_r.value);
                    upd_idx  <= s1_idx;
                    upd_last <= (s1_idx == LAST_IDX);
                    upd_sat  <= s1_sat | q_r.sat;
                end
            end
        end
    end

    q_argmax_tracker #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_tracker (
        .clk        (clk),
        .rst        (rst),
        .beat_valid (upd_valid && upd_ready),
        .beat_first (upd_idx == '0),
        .beat_last  (upd_last),
        .beat_q     (upd_q),
        .beat_idx   (upd_idx),
        .beat_sat   (upd_sat),
        .res_valid  (res_valid),
        .res_q      (res_q),
        .res_idx    (res_idx),
        .res_sat    (res_sat)
    );

endmodule
